// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller.
// Scans NUM_DIGITS digits one slot at a time. Digit data is double-buffered so
// that a new value only appears at a frame boundary. Also handles leading-zero
// blanking, per-digit blink, decimal points, PWM brightness and optional hex
// glyphs. All pin outputs are registered.
module display_scan_ctrl #(
    parameter int NUM_DIGITS       = 4,
    parameter int SCAN_DIV         = 50000,
    parameter int BLINK_FRAMES     = 64,
    parameter int HEX_MODE         = 0,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      load,
    input  logic                      lz_blank,
    input  logic [3:0]                brightness,
    output logic [NUM_DIGITS-1:0]     anodo,
    output logic [6:0]                seven,
    output logic                      dp_out,
    output logic                      frame_tick
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SEL_LAST   = SW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    // Pin level that means "off"; XOR with this turns active-high into pin polarity.
    localparam logic AN_OFF  = (ANODE_ACTIVE_LOW != 0);
    localparam logic SEG_OFF = (SEG_ACTIVE_LOW != 0);

    logic [DW-1:0]           div_cnt_q;
    logic [SW-1:0]           sel_q;
    logic [3:0]              pwm_cnt_q;
    logic [BW-1:0]           blink_cnt_q;
    logic                    blink_phase_q;
    logic [4*NUM_DIGITS-1:0] pend_digits_q, act_digits_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q;
    logic [NUM_DIGITS-1:0]   pend_blink_q, act_blink_q;
    logic                    frame_tick_q;
    logic [NUM_DIGITS-1:0]   anodo_q, anodo_d;
    logic [6:0]              seven_q, seven_d;
    logic                    dp_q, dp_d;

    logic slot_tick;
    logic frame_end;

    assign slot_tick = (div_cnt_q == DIV_LAST);
    assign frame_end = slot_tick && (sel_q == SEL_LAST);

    // Slot prescaler, digit select, PWM phase and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            sel_q        <= '0;
            pwm_cnt_q    <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= slot_tick ? '0 : div_cnt_q + 1'b1;
            if (slot_tick) begin
                sel_q <= (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
            end
            pwm_cnt_q    <= pwm_cnt_q + 4'd1;
            frame_tick_q <= frame_end;
        end
    end

    // Pending/active buffers; a load on the boundary bypasses straight to active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_blink_q  <= '0;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            act_blink_q   <= '0;
        end else begin
            if (load) begin
                pend_digits_q <= digits;
                pend_dp_q     <= dp_in;
                pend_blink_q  <= blink_mask;
            end
            if (frame_end) begin
                act_digits_q <= load ? digits     : pend_digits_q;
                act_dp_q     <= load ? dp_in      : pend_dp_q;
                act_blink_q  <= load ? blink_mask : pend_blink_q;
            end
        end
    end

    // Blink half-period counter, advanced once per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    logic [3:0] nib [NUM_DIGITS];

    // Unpack the active digit buffer into nibbles.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib[i] = act_digits_q[4*i +: 4];
        end
    end

    logic [3:0]            cur_nib;
    logic                  zero_above;
    logic                  lz_hide;
    logic                  blink_hide;
    logic [6:0]            glyph_low;
    logic [6:0]            seg_low;
    logic                  dp_low;
    logic                  pwm_on;
    logic [NUM_DIGITS-1:0] an_vec;

    // Decode the selected digit into next pin values (glyphs held in active-low form).
    always_comb begin
        cur_nib    = nib[sel_q];
        zero_above = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(sel_q) && nib[j] != 4'd0) begin
                zero_above = 1'b0;
            end
        end
        lz_hide    = lz_blank && (sel_q != '0) && zero_above;
        blink_hide = blink_phase_q && act_blink_q[sel_q];

        case (cur_nib)
            4'd0:    glyph_low = 7'b1000000;
            4'd1:    glyph_low = 7'b1111001;
            4'd2:    glyph_low = 7'b0100100;
            4'd3:    glyph_low = 7'b0110000;
            4'd4:    glyph_low = 7'b0011001;
            4'd5:    glyph_low = 7'b0010010;
            4'd6:    glyph_low = 7'b0000010;
            4'd7:    glyph_low = 7'b1111000;
            4'd8:    glyph_low = 7'b0000000;
            4'd9:    glyph_low = 7'b0010000;
            4'd10:   glyph_low = (HEX_MODE != 0) ? 7'b0001000 : 7'b1111111;
            4'd11:   glyph_low = (HEX_MODE != 0) ? 7'b0000011 : 7'b1111111;
            4'd12:   glyph_low = (HEX_MODE != 0) ? 7'b1000110 : 7'b1111111;
            4'd13:   glyph_low = (HEX_MODE != 0) ? 7'b0100001 : 7'b1111111;
            4'd14:   glyph_low = (HEX_MODE != 0) ? 7'b0000110 : 7'b1111111;
            default: glyph_low = (HEX_MODE != 0) ? 7'b0001110 : 7'b1111111;
        endcase

        // A zero-blanked digit keeps its dp; a blinked-off digit loses both.
        seg_low = (blink_hide || lz_hide) ? 7'b1111111 : glyph_low;
        dp_low  = ~(act_dp_q[sel_q] && !blink_hide);

        // First cycle of each slot stays dark to avoid ghosting between digits.
        pwm_on = (brightness == 4'hF) || (pwm_cnt_q < brightness);
        an_vec = '0;
        if (div_cnt_q != '0 && pwm_on) begin
            an_vec[sel_q] = 1'b1;
        end

        anodo_d = an_vec ^ {NUM_DIGITS{AN_OFF}};
        seven_d = seg_low ^ {7{~SEG_OFF}};
        dp_d    = dp_low ^ ~SEG_OFF;
    end

    // Register pin outputs; reset drives every pin to its inactive level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anodo_q <= {NUM_DIGITS{AN_OFF}};
            seven_q <= {7{SEG_OFF}};
            dp_q    <= SEG_OFF;
        end else begin
            anodo_q <= anodo_d;
            seven_q <= seven_d;
            dp_q    <= dp_d;
        end
    end

    assign anodo      = anodo_q;
    assign seven      = seven_q;
    assign dp_out     = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with SCAN_DIV=4, NUM_DIGITS=4.
// Two instances share stimulus: one decimal-only, one with hex glyphs.
// Sample index c = cyc-1 names the internal cycle whose state the registered
// outputs show: slot div=c%4, digit=(c/4)%4, pwm=c%16, frame=c/16.
module tb_display_scan_ctrl;

    localparam logic [6:0] G0  = 7'b1000000;
    localparam logic [6:0] G1  = 7'b1111001;
    localparam logic [6:0] G2  = 7'b0100100;
    localparam logic [6:0] G3  = 7'b0110000;
    localparam logic [6:0] G4  = 7'b0011001;
    localparam logic [6:0] G7  = 7'b1111000;
    localparam logic [6:0] GA  = 7'b0001000;
    localparam logic [6:0] GB  = 7'b0000011;
    localparam logic [6:0] GC  = 7'b1000110;
    localparam logic [6:0] GD  = 7'b0100001;
    localparam logic [6:0] OFF = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dp_in, blink_mask, brightness;
    logic        load, lz_blank;
    logic [3:0]  anodo, anodo_h;
    logic [6:0]  seven, seven_h;
    logic        dp_out, dp_out_h, frame_tick, frame_tick_h;

    int checks = 0;
    int errors = 0;
    int cyc;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    display_scan_ctrl #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .HEX_MODE(0),
        .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in),
        .blink_mask(blink_mask), .load(load), .lz_blank(lz_blank),
        .brightness(brightness), .anodo(anodo), .seven(seven),
        .dp_out(dp_out), .frame_tick(frame_tick)
    );

    display_scan_ctrl #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .HEX_MODE(1),
        .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) dut_h (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in),
        .blink_mask(blink_mask), .load(load), .lz_blank(lz_blank),
        .brightness(brightness), .anodo(anodo_h), .seven(seven_h),
        .dp_out(dp_out_h), .frame_tick(frame_tick_h)
    );

    function automatic logic [3:0] exp_an(int c, int b);
        logic [3:0] onehot;
        onehot = 4'b0001 << ((c / 4) % 4);
        if ((c % 4) != 0 && (b == 15 || (c % 16) < b)) return ~onehot;
        return 4'hF;
    endfunction

    function automatic logic [6:0] glyph_1234(int sel);
        case (sel)
            0: return G4;
            1: return G3;
            2: return G2;
            default: return G1;
        endcase
    endfunction

    // Advance to the sample showing the first cycle of the next frame.
    task automatic to_frame_start();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (((cyc - 1) % 16) != 0 && guard < 40);
    endtask

    task automatic pulse_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; digits = '0; dp_in = '0; blink_mask = '0;
        load = 1'b0; lz_blank = 1'b0; brightness = 4'd15;
        repeat (3) @(negedge clk);
        checks++; if (anodo !== 4'hF) begin errors++; $display("FAIL reset_anodo got %b want 1111", anodo); end
        checks++; if (seven !== OFF) begin errors++; $display("FAIL reset_seven got %b want %b", seven, OFF); end
        checks++; if (dp_out !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", dp_out); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick got %b want 0", frame_tick); end
        checks++; if (anodo_h !== 4'hF || seven_h !== OFF) begin errors++; $display("FAIL reset_hex_inst got %b/%b want 1111/%b", anodo_h, seven_h, OFF); end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        for (int n = 0; n < 32; n++) begin
            int c;
            @(negedge clk);
            c = cyc - 1;
            checks++; if (anodo !== exp_an(c, 15)) begin errors++; $display("FAIL scan_anodo c=%0d got %b want %b", c, anodo, exp_an(c, 15)); end
            checks++; if (seven !== G0) begin errors++; $display("FAIL scan_seven c=%0d got %b want %b", c, seven, G0); end
            checks++; if (dp_out !== 1'b1) begin errors++; $display("FAIL scan_dp c=%0d got %b want 1", c, dp_out); end
            checks++; if (frame_tick !== ((c % 16) == 15)) begin errors++; $display("FAIL scan_frame_tick c=%0d got %b want %b", c, frame_tick, (c % 16) == 15); end
        end
    endtask

    task automatic test_load_sync();
        int guard = 0;
        do begin @(negedge clk); guard++; end while (((cyc - 1) % 16) != 5 && guard < 40);
        digits = 16'h1234;
        pulse_load();
        for (int n = 0; n < 20; n++) begin
            int c = cyc - 1;
            checks++; if (seven !== G0) begin errors++; $display("FAIL load_no_tear c=%0d got %b want %b", c, seven, G0); end
            if ((c % 16) == 15) break;
            @(negedge clk);
        end
        for (int n = 0; n < 16; n++) begin
            int c, sel;
            @(negedge clk);
            c = cyc - 1; sel = (c / 4) % 4;
            checks++; if (seven !== glyph_1234(sel)) begin errors++; $display("FAIL load_show digit=%0d got %b want %b", sel, seven, glyph_1234(sel)); end
        end
    endtask

    task automatic test_lz();
        logic [6:0] exp_s;
        logic       exp_d;
        to_frame_start();
        digits = 16'h0070; dp_in = 4'b1000; lz_blank = 1'b1;
        pulse_load();
        to_frame_start();
        for (int n = 0; n < 16; n++) begin
            int sel = ((cyc - 1) / 4) % 4;
            exp_s = (sel == 3 || sel == 2) ? OFF : (sel == 1) ? G7 : G0;
            exp_d = (sel == 3) ? 1'b0 : 1'b1;
            checks++; if (seven !== exp_s) begin errors++; $display("FAIL lz_on_seven digit=%0d got %b want %b", sel, seven, exp_s); end
            checks++; if (dp_out !== exp_d) begin errors++; $display("FAIL lz_on_dp digit=%0d got %b want %b", sel, dp_out, exp_d); end
            @(negedge clk);
        end
        lz_blank = 1'b0;
        to_frame_start();
        for (int n = 0; n < 16; n++) begin
            int sel = ((cyc - 1) / 4) % 4;
            exp_s = (sel == 1) ? G7 : G0;
            exp_d = (sel == 3) ? 1'b0 : 1'b1;
            checks++; if (seven !== exp_s) begin errors++; $display("FAIL lz_off_seven digit=%0d got %b want %b", sel, seven, exp_s); end
            checks++; if (dp_out !== exp_d) begin errors++; $display("FAIL lz_off_dp digit=%0d got %b want %b", sel, dp_out, exp_d); end
            @(negedge clk);
        end
    endtask

    task automatic test_hex();
        logic [6:0] exp_h;
        to_frame_start();
        digits = 16'hABCD; dp_in = 4'b0000;
        pulse_load();
        to_frame_start();
        for (int n = 0; n < 16; n++) begin
            int sel = ((cyc - 1) / 4) % 4;
            exp_h = (sel == 3) ? GA : (sel == 2) ? GB : (sel == 1) ? GC : GD;
            checks++; if (seven !== OFF) begin errors++; $display("FAIL hex0_blank digit=%0d got %b want %b", sel, seven, OFF); end
            checks++; if (seven_h !== exp_h) begin errors++; $display("FAIL hex1_glyph digit=%0d got %b want %b", sel, seven_h, exp_h); end
            @(negedge clk);
        end
    endtask

    task automatic test_blink();
        logic [6:0] exp_s;
        logic       exp_d;
        to_frame_start();
        digits = 16'h1234; dp_in = 4'b0001; blink_mask = 4'b0001;
        pulse_load();
        to_frame_start();
        for (int n = 0; n < 128; n++) begin
            int c   = cyc - 1;
            int sel = (c / 4) % 4;
            int ph  = ((c / 16) / 2) % 2;
            if (sel == 0) begin
                exp_s = (ph == 1) ? OFF : G4;
                exp_d = (ph == 1) ? 1'b1 : 1'b0;
            end else begin
                exp_s = glyph_1234(sel);
                exp_d = 1'b1;
            end
            checks++; if (seven !== exp_s) begin errors++; $display("FAIL blink_seven c=%0d digit=%0d got %b want %b", c, sel, seven, exp_s); end
            checks++; if (dp_out !== exp_d) begin errors++; $display("FAIL blink_dp c=%0d digit=%0d got %b want %b", c, sel, dp_out, exp_d); end
            @(negedge clk);
        end
    endtask

    task automatic test_pwm();
        int bs [3] = '{4, 14, 0};
        for (int k = 0; k < 3; k++) begin
            brightness = 4'(bs[k]);
            to_frame_start();
            for (int n = 0; n < 16; n++) begin
                int c = cyc - 1;
                checks++; if (anodo !== exp_an(c, bs[k])) begin errors++; $display("FAIL pwm_anodo b=%0d c=%0d got %b want %b", bs[k], c, anodo, exp_an(c, bs[k])); end
                checks++; if (anodo_h !== exp_an(c, bs[k])) begin errors++; $display("FAIL pwm_anodo_hex b=%0d c=%0d got %b want %b", bs[k], c, anodo_h, exp_an(c, bs[k])); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        brightness = 4'd15; lz_blank = 1'b0; blink_mask = 4'b0000; dp_in = 4'b0000;
        to_frame_start();
        @(negedge clk);
        @(negedge clk);
        checks++; if (anodo !== 4'b1110) begin errors++; $display("FAIL premid_anodo got %b want 1110", anodo); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (anodo !== 4'hF) begin errors++; $display("FAIL midrst_anodo got %b want 1111", anodo); end
        checks++; if (seven !== OFF) begin errors++; $display("FAIL midrst_seven got %b want %b", seven, OFF); end
        checks++; if (dp_out !== 1'b1) begin errors++; $display("FAIL midrst_dp got %b want 1", dp_out); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL midrst_frame_tick got %b want 0", frame_tick); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 16; n++) begin
            int c;
            @(negedge clk);
            c = cyc - 1;
            checks++; if (seven !== G0) begin errors++; $display("FAIL postrst_seven c=%0d got %b want %b", c, seven, G0); end
            checks++; if (anodo !== exp_an(c, 15)) begin errors++; $display("FAIL postrst_anodo c=%0d got %b want %b", c, anodo, exp_an(c, 15)); end
            checks++; if (frame_tick !== ((c % 16) == 15)) begin errors++; $display("FAIL postrst_frame_tick c=%0d got %b want %b", c, frame_tick, (c % 16) == 15); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_sync();
        test_lz();
        test_hex();
        test_blink();
        test_pwm();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
